regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter ADDR_W, default 4, select width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 WriteEnable  input  1  write strobe for port W.
REQ-007 SelectInput  input  ADDR_W  write address.
REQ-008 In  input  WIDTH  write data.
REQ-009 ReadEnable  input  1  capture strobe for read ports A and B.
REQ-010 SelectA  input  ADDR_W  read address, port A.
REQ-011 SelectB  input  ADDR_W  read address, port B.
REQ-012 Reserve  input  1  marks a register as pending a future write.
REQ-013 ReserveSelect  input  ADDR_W  register to reserve.
REQ-014 A  output  WIDTH  registered read data, port A.
REQ-015 B  output  WIDTH  registered read data, port B.
REQ-016 BusyA  output  1  registered pending flag for the register captured on A.
REQ-017 BusyB  output  1  registered pending flag for the register captured on B.

Function
REQ-018 Storage SHALL be DEPTH words of WIDTH bits plus DEPTH busy bits.
REQ-019 WriteEnable=1 SHALL store In into register SelectInput at the clock edge.
REQ-020 Any write SHALL clear the busy bit of register SelectInput at the same edge.
REQ-021 Reserve=1 SHALL set the busy bit of register ReserveSelect at the clock edge.
REQ-022 Reserve and write to the same register in the same cycle SHALL leave busy set (reserve wins); the data SHALL still be written.
REQ-023 Reserve and write to different registers in the same cycle SHALL both take effect.
REQ-024 ReadEnable=1 SHALL capture A/B/BusyA/BusyB at the edge; read latency is exactly one cycle.
REQ-025 ReadEnable=0 SHALL hold A, B, BusyA, BusyB unchanged.
REQ-026 Bypass: if WriteEnable=1 and SelectInput equals SelectA (or SelectB) in the capture cycle, A (or B) SHALL capture In, not the old stored value.
REQ-027 Busy bypass: BusyA/BusyB SHALL reflect the post-edge busy bit of the selected register, i.e. including same-cycle write-clear and reserve-set per REQ-020..REQ-022.
REQ-028 SelectA = SelectB SHALL return identical data and busy on both ports.
REQ-029 ZERO_REG=1: writes and reserves to register 0 SHALL be ignored; reads of register 0 SHALL return 0 with busy 0, including under bypass.
REQ-030 ZERO_REG=0: register 0 SHALL behave as any other register.
REQ-031 No arithmetic on data; widths SHALL match exactly, no truncation or extension.

Reset
REQ-032 Reset=1 at an edge SHALL clear all DEPTH registers, all busy bits, A, B, BusyA, BusyB to 0.
REQ-033 Reset SHALL take priority over WriteEnable, Reserve and ReadEnable in the same cycle.
REQ-034 Reset asserted mid-sequence SHALL discard all pending reservations; first valid write/read is possible the edge after Reset deasserts.
REQ-035 Initial power-up state SHALL be undefined until the first Reset edge; no initial blocks are relied upon.

Verification
REQ-036 Reset; write 0x1234 to r3; next cycle ReadEnable, SelectA=3 -> A=0x1234 one cycle later, BusyA=0.
REQ-037 Same cycle WriteEnable, SelectInput=5, In=0xBEEF, ReadEnable, SelectA=SelectB=5 (r5 was 0x0000) -> A=B=0xBEEF after one edge.
REQ-038 Reserve r7; read r7 -> BusyA=1; write 0x00AA to r7 while reading r7 -> A=0x00AA, BusyA=0.
REQ-039 Reserve r2 and write r2=0x0F0F same cycle, then read r2 -> A=0x0F0F, BusyA=1.
REQ-040 ZERO_REG=1: write 0xFFFF to r0 and reserve r0, read r0 with bypass -> A=0, BusyA=0; ZERO_REG=0 same stimulus -> A=0xFFFF, BusyA=1.
REQ-041 Fill all registers and reserve r9, assert Reset with WriteEnable=1, then read r9 and r15 -> A=B=0, BusyA=BusyB=0; hold ReadEnable=0 while changing SelectA -> A unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with one write port, two registered read ports and per-register busy (pending-write) bits.
// Read capture bypasses same-cycle writes and reservations, so A/B/BusyA/BusyB reflect post-edge state.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] SelectInput,
    input  logic [WIDTH-1:0]  In,
    input  logic              ReadEnable,
    input  logic [ADDR_W-1:0] SelectA,
    input  logic [ADDR_W-1:0] SelectB,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveSelect,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              BusyA,
    output logic              BusyB
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             writeOk;
    logic             reserveOk;
    logic [WIDTH-1:0] nextA;
    logic [WIDTH-1:0] nextB;
    logic             nextBusyA;
    logic             nextBusyB;

    // With a hardwired zero register, r0 is never written or reserved, so it stays 0/idle after reset.
    always_comb begin
        writeOk   = WriteEnable && !((ZERO_REG != 0) && (SelectInput == '0));
        reserveOk = Reserve && !((ZERO_REG != 0) && (ReserveSelect == '0));
    end

    // Reserve is applied after the write-clear so it wins on a same-register collision.
    always_comb begin
        busyNext = busy;
        if (writeOk) begin
            busyNext[SelectInput] = 1'b0;
        end
        if (reserveOk) begin
            busyNext[ReserveSelect] = 1'b1;
        end
    end

    always_comb begin
        nextA     = regs[SelectA];
        nextB     = regs[SelectB];
        nextBusyA = busyNext[SelectA];
        nextBusyB = busyNext[SelectB];
        if (writeOk && (SelectInput == SelectA)) begin
            nextA = In;
        end
        if (writeOk && (SelectInput == SelectB)) begin
            nextB = In;
        end
        if ((ZERO_REG != 0) && (SelectA == '0)) begin
            nextA     = '0;
            nextBusyA = 1'b0;
        end
        if ((ZERO_REG != 0) && (SelectB == '0)) begin
            nextB     = '0;
            nextBusyB = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            A     <= '0;
            B     <= '0;
            BusyA <= 1'b0;
            BusyB <= 1'b0;
        end else begin
            if (writeOk) begin
                regs[SelectInput] <= In;
            end
            busy <= busyNext;
            if (ReadEnable) begin
                A     <= nextA;
                B     <= nextB;
                BusyA <= nextBusyA;
                BusyB <= nextBusyB;
            end
        end
    end

endmodule
